opsum_buffer: RTL and testbench

//  Write-side counterpart of the ipsum path. Collects 16-bit output psums from the Reducer, one per PE row per capture.

---
 rtl/opsum_buffer.sv | 136 +++++++++++++
 tb/tb_opsum_buffer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opsum_buffer.sv
// opsum_buffer: collects one 16-bit psum per PE row per capture from the
// Reducer, pairs two consecutive captures per row into a 32-bit word and
// streams the words, row by row, to the GLB write port.
// Optional build macro: OPSUM_RELU_EN clamps each negative 16-bit output
// field to zero at the output mux. The stored slots are never modified.
module opsum_buffer #(
    parameter int ROW_NUM = 32,
    parameter int PSUM_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cap_valid,
    output logic                      cap_ready,
    input  logic [ROW_NUM*PSUM_W-1:0] opsum_in,
    input  logic                      flush,
    input  logic [5:0]                row_en,
    output logic                      valid_op,
    input  logic                      ready_op,
    output logic [2*PSUM_W-1:0]       opsum_out,
    output logic                      drain_done,
    output logic [1:0]                state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high. The producer keeps valid and its data stable until that
    // edge; ready may change freely. Input side: cap_valid/cap_ready with
    // opsum_in. Output side: valid_op/ready_op with opsum_out.

    localparam int          PTR_W     = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
    localparam logic [5:0]  ROW_NUM_L = 6'(ROW_NUM);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HALF  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PSUM_W-1:0]  slot0 [ROW_NUM];
    logic [PSUM_W-1:0]  slot1 [ROW_NUM];
    logic [5:0]         rows_lat;
    logic [PTR_W-1:0]   row_ptr;

    logic               capture;
    logic               enter_drain;
    logic               last_row;
    logic               drain_exit;
    logic               handshake;
    logic [5:0]         rows_clamped;

    // Optional ReLU on one output field; the default build passes it through.
    function automatic logic [PSUM_W-1:0] out_field(input logic [PSUM_W-1:0] x);
`ifdef OPSUM_RELU_EN
        return x[PSUM_W-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    // Decoded control conditions shared by the FSM and the datapath.
    always_comb begin
        capture      = cap_valid && (state != S_DRAIN);
        enter_drain  = (state == S_HALF) && (cap_valid || flush);
        last_row     = (6'(row_ptr) == (rows_lat - 6'd1));
        handshake    = (state == S_DRAIN) && (rows_lat != 6'd0) && ready_op;
        drain_exit   = (state == S_DRAIN) &&
                       ((rows_lat == 6'd0) || (ready_op && last_row));
        rows_clamped = (row_en > ROW_NUM_L) ? ROW_NUM_L : row_en;
    end

    // State register; reset aborts any drain in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a capture in HALF wins over a simultaneous flush,
    // and a flush in IDLE is ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (capture)     state_nxt = S_HALF;
            S_HALF:  if (enter_drain) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_exit)  state_nxt = S_IDLE;
            default:                  state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from the state register; words are zero outside DRAIN.
    always_comb begin
        cap_ready = (state != S_DRAIN);
        valid_op  = (state == S_DRAIN) && (rows_lat != 6'd0);
        opsum_out = '0;
        if (valid_op) begin
            opsum_out = {out_field(slot0[row_ptr]), out_field(slot1[row_ptr])};
        end
        state_dbg = state;
    end

    // Slot storage, latched row count, row pointer and the done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < ROW_NUM; r++) begin
                slot0[r] <= '0;
                slot1[r] <= '0;
            end
            rows_lat   <= '0;
            row_ptr    <= '0;
            drain_done <= 1'b0;
        end else begin
            drain_done <= drain_exit;
            if ((state == S_IDLE) && capture) begin
                for (int r = 0; r < ROW_NUM; r++) begin
                    slot0[r] <= opsum_in[r*PSUM_W +: PSUM_W];
                end
            end
            if (enter_drain) begin
                // A flush without a capture closes the pair with zeros.
                for (int r = 0; r < ROW_NUM; r++) begin
                    slot1[r] <= cap_valid ? opsum_in[r*PSUM_W +: PSUM_W] : '0;
                end
                rows_lat <= rows_clamped;
                row_ptr  <= '0;
            end else if (drain_exit) begin
                row_ptr <= '0;
            end else if (handshake) begin
                row_ptr <= row_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_opsum_buffer.sv
// Bench for opsum_buffer: drivers issue captures/flushes and push expected
// GLB words into exp_q; a negedge monitor pops and compares every accepted
// word, checks stall stability, back-pressure and the drain_done pulse.
`timescale 1ns/1ps
module tb_opsum_buffer;

    localparam int ROW_NUM = 32;
    localparam int PSUM_W  = 16;
    localparam int DW      = ROW_NUM * PSUM_W;

    logic          clk = 1'b0;
    logic          reset;
    logic          cap_valid;
    logic          cap_ready;
    logic [DW-1:0] opsum_in;
    logic          flush;
    logic [5:0]    row_en;
    logic          valid_op;
    logic          ready_op;
    logic [31:0]   opsum_out;
    logic          drain_done;
    logic [1:0]    state_dbg;

    opsum_buffer #(.ROW_NUM(ROW_NUM), .PSUM_W(PSUM_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cap_valid  (cap_valid),
        .cap_ready  (cap_ready),
        .opsum_in   (opsum_in),
        .flush      (flush),
        .row_en     (row_en),
        .valid_op   (valid_op),
        .ready_op   (ready_op),
        .opsum_out  (opsum_out),
        .drain_done (drain_done),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [15:0] m_slot0 [ROW_NUM];
    bit          model_half = 1'b0;
    int          done_in = 0;
    int          words_seen = 0;
    bit          ready_rand = 1'b0;
    bit          stalled_prev = 1'b0;
    logic [31:0] prev_word = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] relu(input logic [15:0] x);
`ifdef OPSUM_RELU_EN
        return x[15] ? 16'h0000 : x;
`else
        return x;
`endif
    endfunction

    function automatic logic [DW-1:0] pattern(input logic [15:0] base);
        logic [DW-1:0] d;
        for (int r = 0; r < ROW_NUM; r++) d[r*16 +: 16] = base + 16'(r);
        return d;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int r = 0; r < ROW_NUM; r++) d[r*16 +: 16] = 16'($urandom);
        return d;
    endfunction

    // Reference model: a closed pair yields one word per active row.
    task automatic close_pair(input logic [DW-1:0] second, input logic [5:0] re);
        int n;
        n = (int'(re) > ROW_NUM) ? ROW_NUM : int'(re);
        for (int r = 0; r < n; r++)
            exp_q.push_back({relu(m_slot0[r]), relu(second[r*16 +: 16])});
        if (n == 0) done_in = 2;
        model_half = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    initial begin
        ready_op = 1'b1;
        forever begin
            @(posedge clk); #1;
            ready_op = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic do_capture(input logic [DW-1:0] data, input logic fl);
        int n;
        logic [5:0] re;
        @(posedge clk); #1;
        cap_valid = 1'b1;
        opsum_in  = data;
        flush     = fl;
        n = 0;
        forever begin
            @(negedge clk);
            if (cap_ready) break;
            n++;
            if (n > 500) begin
                check("capture_timeout", 32'(cap_ready), 32'd1);
                cap_valid = 1'b0;
                flush     = 1'b0;
                return;
            end
        end
        re = row_en;
        @(posedge clk); #1;
        cap_valid = 1'b0;
        flush     = 1'b0;
        if (!model_half) begin
            for (int r = 0; r < ROW_NUM; r++) m_slot0[r] = data[r*16 +: 16];
            model_half = 1'b1;
        end else begin
            close_pair(data, re);
        end
    endtask

    task automatic do_flush();
        logic [5:0] re;
        @(posedge clk); #1;
        flush = 1'b1;
        re = row_en;
        @(posedge clk); #1;
        flush = 1'b0;
        if (model_half) close_pair('0, re);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(negedge clk); #1;
            if (exp_q.size() == 0 && done_in == 0) break;
            n++;
            if (n > 2000) begin
                check("drain_timeout", 32'(exp_q.size()), 32'd0);
                exp_q.delete();
                done_in = 0;
                break;
            end
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            stalled_prev = 1'b0;
        end else begin
            check("drain_done", 32'(drain_done), 32'(done_in == 1));
            if (done_in > 0) done_in--;
            if (exp_q.size() > 0) begin
                check("cap_ready_in_drain", 32'(cap_ready), 32'd0);
                check("valid_op_in_drain", 32'(valid_op), 32'd1);
            end
            if (valid_op) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", opsum_out, 32'hxxxx_xxxx);
                end else begin
                    if (stalled_prev) check("stall_stable", opsum_out, prev_word);
                    if (ready_op) begin
                        check("word", opsum_out, exp_q.pop_front());
                        words_seen++;
                        if (exp_q.size() == 0) done_in = 1;
                    end
                end
            end
            stalled_prev = valid_op && !ready_op;
            prev_word    = opsum_out;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int n;
        logic [DW-1:0] d;

        reset     = 1'b1;
        cap_valid = 1'b0;
        flush     = 1'b0;
        opsum_in  = '0;
        row_en    = 6'd4;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_op", 32'(valid_op), 32'd0);
        check("rst_opsum_out", opsum_out, 32'd0);
        check("rst_cap_ready", 32'(cap_ready), 32'd1);
        check("rst_drain_done", 32'(drain_done), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        reset = 1'b0;

        // Basic drain: four words on consecutive cycles.
        base = words_seen;
        row_en = 6'd4;
        do_capture(pattern(16'h0100), 1'b0);
        check("half_state", 32'(state_dbg), 32'd1);
        do_capture(pattern(16'h0200), 1'b0);
        wait_idle();
        check("basic_count", 32'(words_seen - base), 32'd4);

        // Flush with one row, then a flush in IDLE.
        base = words_seen;
        row_en = 6'd1;
        d = rand_data();
        d[15:0] = 16'h1234;
        do_capture(d, 1'b0);
        do_flush();
        wait_idle();
        check("flush_count", 32'(words_seen - base), 32'd1);
        do_flush();
        repeat (4) @(negedge clk);
        #1;
        check("idle_flush_state", 32'(state_dbg), 32'd0);
        check("idle_flush_count", 32'(words_seen - base), 32'd1);

        // Capture and flush together in HALF: capture wins.
        d = rand_data();
        d[15:0] = 16'h0011;
        do_capture(d, 1'b0);
        d[15:0] = 16'h00AA;
        do_capture(d, 1'b1);
        wait_idle();

        // Zero rows, then more rows than exist.
        base = words_seen;
        row_en = 6'd0;
        do_capture(rand_data(), 1'b0);
        do_capture(rand_data(), 1'b0);
        wait_idle();
        check("zero_rows_count", 32'(words_seen - base), 32'd0);
        row_en = 6'd40;
        do_capture(rand_data(), 1'b0);
        do_capture(rand_data(), 1'b0);
        wait_idle();
        check("over_rows_count", 32'(words_seen - base), 32'd32);

        // ReLU field check on row 0.
        row_en = 6'd1;
        d = rand_data();
        d[15:0] = 16'hFFF0;
        do_capture(d, 1'b0);
        d[15:0] = 16'h0005;
        do_capture(d, 1'b0);
        wait_idle();

        // Back-pressure: random ready, capture held during drain, row_en
        // changed mid-drain only applies to the next drain.
        base = words_seen;
        ready_rand = 1'b1;
        row_en = 6'd32;
        do_capture(rand_data(), 1'b0);
        do_capture(rand_data(), 1'b0);
        fork
            do_capture(rand_data(), 1'b0);
            begin
                repeat (5) @(negedge clk);
                #2;
                row_en = 6'd3;
            end
        join
        do_capture(rand_data(), 1'b0);
        wait_idle();
        check("bp_count", 32'(words_seen - base), 32'd35);

        // Randomized pairs.
        for (int i = 0; i < 12; i++) begin
            ready_rand = 1'($urandom_range(0, 1));
            row_en = 6'($urandom_range(0, 40));
            do_capture(rand_data(), 1'b0);
            if ($urandom_range(0, 2) == 0) do_flush();
            else do_capture(rand_data(), 1'($urandom_range(0, 1)));
            wait_idle();
        end
        ready_rand = 1'b0;

        // Reset in the middle of a drain.
        base = words_seen;
        row_en = 6'd4;
        do_capture(rand_data(), 1'b0);
        do_capture(rand_data(), 1'b0);
        n = 0;
        while (words_seen < base + 2 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check("pre_reset_words", 32'(words_seen - base), 32'd2);
        reset = 1'b1;
        #1;
        check("mid_rst_valid_op", 32'(valid_op), 32'd0);
        check("mid_rst_state", 32'(state_dbg), 32'd0);
        check("mid_rst_opsum_out", opsum_out, 32'd0);
        exp_q.delete();
        done_in = 0;
        model_half = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk); #1;
        check("post_rst_cap_ready", 32'(cap_ready), 32'd1);
        check("post_rst_valid_op", 32'(valid_op), 32'd0);

        repeat (3) @(negedge clk);
        #1;
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
